// File: rtl/bch_pkg.sv
// Shared constants, state type and GF(2^4) helpers for the BCH(15,7) decoder.
// GF arithmetic uses polynomial basis with primitive polynomial x^4+x+1.
package bch_pkg;

    localparam int N = 15;
    localparam int K = 7;
    localparam int M = 4;

    localparam logic [M:0]   PRIM_POLY  = 5'b10011;
    localparam logic [M-1:0] ALPHA_INV1 = 4'b1001;
    localparam logic [M-1:0] ALPHA_INV2 = 4'b1101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Shift-and-add multiply with reduction by the primitive polynomial.
    function automatic logic [M-1:0] gf_mult(input logic [M-1:0] a,
                                             input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < M; i++) begin
            if (b[i])
                acc = acc ^ p;
            if (p[M-1])
                p = (p << 1) ^ PRIM_POLY[M-1:0];
            else
                p = p << 1;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bch_chien_cell.sv
// One Chien search step: tests Lambda at the current position and advances
// the locator terms by alpha^-1 and alpha^-2. Ports: r1, r2 in; is_root, r1_next, r2_next out.
module bch_chien_cell
    import bch_pkg::*;
(
    input  logic [M-1:0] r1,
    input  logic [M-1:0] r2,
    output logic         is_root,
    output logic [M-1:0] r1_next,
    output logic [M-1:0] r2_next
);

    localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

    // r1/r2 already hold lambda_i * alpha^(-i*k), so the sum is Lambda(alpha^-k).
    assign is_root = ((ONE ^ r1 ^ r2) == '0);
    assign r1_next = gf_mult(r1, ALPHA_INV1);
    assign r2_next = gf_mult(r2, ALPHA_INV2);

endmodule

// File: rtl/bch_chien_corrector.sv
// Sequential Chien search and bit correction for BCH(15,7) t=2, one position per clock.
// Ports: clk, rst, in_valid/in_ready + lambda1, lambda2, codeword_in; out_valid/out_ready + codeword_out, data_out, err_count, uncorrectable.
module bch_chien_corrector
    import bch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   lambda1,
    input  logic [3:0]   lambda2,
    input  logic [14:0]  codeword_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [14:0]  codeword_out,
    output logic [6:0]   data_out,
    output logic [1:0]   err_count,
    output logic         uncorrectable
);

    localparam logic [3:0] LAST_K = 4'(N - 1);

    state_t       state;
    state_t       state_next;
    logic [M-1:0] r1;
    logic [M-1:0] r2;
    logic [M-1:0] r1_next;
    logic [M-1:0] r2_next;
    logic [N-1:0] cw;
    logic [N-1:0] raw;
    logic [N-1:0] cw_flip;
    logic [3:0]   k;
    logic [1:0]   roots;
    logic [1:0]   roots_inc;
    logic [1:0]   deg;
    logic         is_root;

    bch_chien_cell u_cell (
        .r1      (r1),
        .r2      (r2),
        .is_root (is_root),
        .r1_next (r1_next),
        .r2_next (r2_next)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign data_out  = codeword_out[N-1:N-K];

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid) state_next = RUN;
            RUN:  if (k == LAST_K) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Corrected word and root count as they will be after this RUN cycle.
    always_comb begin
        cw_flip   = cw;
        roots_inc = roots;
        if (is_root) begin
            cw_flip[k] = ~cw[k];
            if (roots != 2'd3)
                roots_inc = roots + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1            <= '0;
            r2            <= '0;
            cw            <= '0;
            raw           <= '0;
            k             <= '0;
            roots         <= '0;
            deg           <= '0;
            codeword_out  <= '0;
            err_count     <= '0;
            uncorrectable <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        r1    <= lambda1;
                        r2    <= lambda2;
                        cw    <= codeword_in;
                        raw   <= codeword_in;
                        k     <= '0;
                        roots <= '0;
                        if (lambda2 != '0)
                            deg <= 2'd2;
                        else if (lambda1 != '0)
                            deg <= 2'd1;
                        else
                            deg <= 2'd0;
                    end
                end
                RUN: begin
                    r1    <= r1_next;
                    r2    <= r2_next;
                    cw    <= cw_flip;
                    roots <= roots_inc;
                    if (k != LAST_K)
                        k <= k + 4'd1;
                    // Result registers load on the final position so DONE
                    // presents them immediately.
                    if (k == LAST_K) begin
                        if (roots_inc == deg) begin
                            codeword_out  <= cw_flip;
                            err_count     <= roots_inc;
                            uncorrectable <= 1'b0;
                        end else begin
                            codeword_out  <= raw;
                            err_count     <= 2'd0;
                            uncorrectable <= 1'b1;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bch_chien_corrector.sv
// Scoreboard bench for bch_chien_corrector: directed and random words
// checked against a log/antilog GF(16) reference model.
module tb_bch_chien_corrector;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  lambda1;
    logic [3:0]  lambda2;
    logic [14:0] codeword_in;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] codeword_out;
    logic [6:0]  data_out;
    logic [1:0]  err_count;
    logic        uncorrectable;

    bch_chien_corrector dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .lambda1       (lambda1),
        .lambda2       (lambda2),
        .codeword_in   (codeword_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .codeword_out  (codeword_out),
        .data_out      (data_out),
        .err_count     (err_count),
        .uncorrectable (uncorrectable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] cw;
        int          err;
        bit          unc;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   alog[15];
    int   lg[16];
    bit   bp_random = 0;
    bit   bp_value = 1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
        end
    endfunction

    function automatic int gmul(int a, int b);
        if (a == 0 || b == 0)
            return 0;
        return alog[(lg[a] + lg[b]) % 15];
    endfunction

    // Evaluate Lambda at alpha^-k for every position and apply the degree rule.
    function automatic exp_t model(int l1, int l2, logic [14:0] w);
        exp_t e;
        int roots = 0;
        int deg;
        logic [14:0] fixed = w;
        for (int kk = 0; kk < 15; kk++) begin
            int x = alog[(15 - kk) % 15];
            int v = 1 ^ gmul(l1, x) ^ gmul(l2, gmul(x, x));
            if (v == 0) begin
                roots++;
                fixed[kk] = ~fixed[kk];
            end
        end
        deg = (l2 != 0) ? 2 : ((l1 != 0) ? 1 : 0);
        if (roots == deg) begin
            e.cw = fixed; e.err = roots; e.unc = 0;
        end else begin
            e.cw = w; e.err = 0; e.unc = 1;
        end
        e.acc = 0;
        return e;
    endfunction

    task automatic send(logic [3:0] l1, logic [3:0] l2, logic [14:0] w);
        int n = 0;
        bit ok = 0;
        exp_t e;
        @(posedge clk); #1;
        lambda1 = l1; lambda2 = l2; codeword_in = w; in_valid = 1'b1;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else n++;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
        end else begin
            e = model(int'(l1), int'(l2), w);
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lambda1 = 4'($urandom);
        lambda2 = 4'($urandom);
        codeword_in = 15'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: %0d results pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_random) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = bp_value;
        end
    end

    initial begin
        exp_t e;
        bit prev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 0;
            end else begin
                if (out_valid && !prev && sb.size() > 0)
                    chk("latency", cyc - sb[0].acc, 16);
                prev = out_valid;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_output: out_valid=1 expected no pending word");
                    end else begin
                        e = sb.pop_front();
                        chk("codeword_out", int'(codeword_out), int'(e.cw));
                        chk("data_out", int'(data_out), int'(e.cw[14:8]));
                        chk("err_count", int'(err_count), e.err);
                        chk("uncorrectable", int'(uncorrectable), int'(e.unc));
                        chk("in_ready_in_done", int'(in_ready), 0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int n;
        a = 1;
        for (int i = 0; i < 15; i++) begin
            alog[i] = a;
            lg[a] = i;
            a = a << 1;
            if ((a & 16) != 0) a = a ^ 19;
        end
        lg[0] = 0;

        rst = 1'b1; in_valid = 1'b0;
        lambda1 = '0; lambda2 = '0; codeword_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_codeword_out", int'(codeword_out), 0);
        chk("reset_err_count", int'(err_count), 0);
        chk("reset_uncorrectable", int'(uncorrectable), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(4'h0, 4'h0, 15'h1234);  drain();
        send(4'b1000, 4'h0, 15'h0008); drain();
        send(4'b0111, 4'b0110, 15'h0021); drain();
        send(4'h0, 4'b0001, 15'h7FFF); drain();

        // Backpressure: hold out_ready low and watch the result stay put.
        bp_value = 0;
        @(posedge clk); #2;
        send(4'b1000, 4'h0, 15'h0008);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", int'(out_valid), 1);
        #2;
        in_valid = 1'b1; lambda1 = 4'h5; lambda2 = 4'h3; codeword_in = 15'h5555;
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_codeword_out", int'(codeword_out), 0);
            chk("bp_err_count", int'(err_count), 1);
            chk("bp_uncorrectable", int'(uncorrectable), 0);
        end
        in_valid = 1'b0;
        bp_value = 1;
        @(posedge clk); #2;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", int'(in_ready), 1);
        chk("bp_release_out_valid", int'(out_valid), 0);
        drain();

        // Reset while the search is at position 7.
        send(4'h9, 4'hC, 15'h2A5B);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_codeword_out", int'(codeword_out), 0);
        if (sb.size() > 0) void'(sb.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        send(4'b0111, 4'b0110, 15'h0021); drain();

        bp_random = 1;
        for (int t = 0; t < 40; t++) begin
            logic [14:0] w;
            logic [3:0] l1;
            logic [3:0] l2;
            int i;
            int j;
            int mode;
            w = 15'($urandom);
            mode = $urandom_range(0, 3);
            i = $urandom_range(0, 14);
            j = (i + $urandom_range(1, 14)) % 15;
            l1 = '0; l2 = '0;
            case (mode)
                1: begin
                    l1 = 4'(alog[i]);
                    w[i] = ~w[i];
                end
                2: begin
                    l1 = 4'(alog[i] ^ alog[j]);
                    l2 = 4'(alog[(i + j) % 15]);
                    w[i] = ~w[i];
                    w[j] = ~w[j];
                end
                3: begin
                    l1 = 4'($urandom);
                    l2 = 4'($urandom);
                end
                default: begin
                end
            endcase
            send(l1, l2, w);
        end
        drain();
        bp_random = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bch_chien_corrector.md
Name: bch_chien_corrector

Overview:
- Sequential Chien search and bit-correction stage for the BCH(15,7) t=2 decoder over GF(2^4), primitive polynomial x^4+x+1.
- Sits directly downstream of the combinational Berlekamp-Massey block and consumes its lambda1/lambda2 locator coefficients together with the buffered received codeword.
- Evaluates Lambda(x)=1+lambda1*x+lambda2*x^2 at alpha^-k for k=0..14, one position per clock, and flips bit k of the codeword on every root.
- Flags the word as uncorrectable when the root count does not match the degree of Lambda.

Parameters:
- N, 15, codeword length in bits (fixed by the code; other values unsupported).
- M, 4, GF symbol width in bits.
- K, 7, message length; data_out carries bits [N-1:N-K] of the corrected word.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  lambda1, lambda2 and codeword_in are valid.
- in_ready  out  1  block can accept a word.
- lambda1  in  M  locator coefficient 1 (GF(16), polynomial basis).
- lambda2  in  M  locator coefficient 2.
- codeword_in  in  N  received word; bit k is the coefficient of x^k.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- codeword_out  out  N  corrected word, or the raw word if uncorrectable.
- data_out  out  K  codeword_out[N-1:N-K].
- err_count  out  2  number of bits flipped (0..2).
- uncorrectable  out  1  root count is not equal to deg(Lambda).

Behaviour:
- One clock; reset is asynchronous and active-high. Ports are named clk and rst.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - codeword_out=0, err_count=0, uncorrectable=0.
  - All internal registers are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch r1<=lambda1, r2<=lambda2 and cw<=codeword_in, capture the raw word, set k<=0 and roots<=0, then go to RUN.
  - deg is latched as follows: 2 if lambda2!=0; 1 if lambda2==0 and lambda1!=0; otherwise 0.
- RUN (exactly N cycles, k=0..14):
  - Each cycle compute s=1^r1^r2.
  - If s==0: cw[k]<=~cw[k] and roots<=roots+1, saturating at 3.
  - Then update r1<=r1*alpha^14 (alpha^-1) and r2<=r2*alpha^13 (alpha^-2), and k<=k+1.
  - After k=14 go to DONE. The cycle counter does not wrap inside RUN.
- DONE:
  - out_valid=1.
  - If roots==deg: codeword_out=cw, err_count=roots, uncorrectable=0.
  - Otherwise: codeword_out=raw word, err_count=0, uncorrectable=1.
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE. The output registers keep their values, and out_valid drops the next cycle.
- Latency: accepting edge to out_valid is N+1=16 cycles. Throughput is one word per 17 cycles minimum.
- in_ready is 0 in RUN and DONE. in_valid is ignored outside IDLE, and upstream must hold the word until it is accepted.
- lambda1=lambda2=0 (no error): runs the full 15 cycles, no roots, err_count=0, uncorrectable=0.
- If rst asserts mid-RUN or mid-DONE: the block returns to IDLE immediately, the partial result is discarded, and out_valid=0.
- All GF arithmetic is M-bit XOR/constant multiply. No width growth.

Decomposition:
- Shared package bch_pkg holds:
  - N, K, M.
  - The primitive polynomial constant.
  - ALPHA_INV1 = 4'b1001 (alpha^14) and ALPHA_INV2 = 4'b1101 (alpha^13).
  - The state enum typedef.
  - gf_mult, reused from the existing GF tables.
- Sub-module bch_chien_cell (combinational):
  - Takes r1 and r2.
  - Outputs is_root and the next r1/r2 values via constant multipliers.

Test Plan:
- No error: lambda1=0, lambda2=0, codeword_in=15'h1234 -> after 16 cycles: out_valid=1, codeword_out=15'h1234, err_count=0, uncorrectable=0.
- Single error at bit 3: lambda1=4'b1000 (alpha^3), lambda2=0, codeword_in=15'h0008 -> codeword_out=15'h0000, err_count=1, uncorrectable=0.
- Double error at bits 0 and 5: lambda1=4'b0111 (alpha^10), lambda2=4'b0110 (alpha^5), codeword_in=15'h0021 -> codeword_out=15'h0000, err_count=2.
- Uncorrectable: lambda1=0, lambda2=4'b0001 (Lambda=(1+x)^2, one distinct root, deg 2), codeword_in=15'h7FFF -> codeword_out=15'h7FFF, err_count=0, uncorrectable=1.
- Backpressure: single-error case with out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst at RUN cycle 7 -> state IDLE, out_valid=0, in_ready=1. A fresh double-error word then completes correctly.
